// File: rtl/uart_pkg.sv
// Shared types and legal parameter bounds for the UART transmit and receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int CLK_PER_BAUD_MIN = 2;
  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  // data_xor is the XOR of all payload bits; odd mode inverts it so the total count of ones is odd.
  function automatic logic parity_bit(input logic data_xor, input parity_e mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last clock of each line bit. It is shared with the receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_PER_BAUD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  if (CLK_PER_BAUD < CLK_PER_BAUD_MIN) begin : g_bad_clk_per_baud
    $error("uart_baud_tick: CLK_PER_BAUD must be >= 2");
  end

  localparam int CNT_W = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register for back-to-back frames.
// Line-break support is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_frame #(
  parameter int CLK_PER_BAUD = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  import uart_pkg::*;

  if (CLK_PER_BAUD < CLK_PER_BAUD_MIN) begin : g_bad_clk_per_baud
    $error("uart_tx_frame: CLK_PER_BAUD must be >= 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_ODD : ((PARITY == 2) ? PAR_EVEN : PAR_NONE);

  tx_state_e            state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tick, restart, load, accept, idle_block;

  uart_baud_tick #(
    .CLK_PER_BAUD(CLK_PER_BAUD)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

`ifdef UART_TX_BREAK_EN
  // After a break is released the counter runs once more so the line idles high for a full bit.
  logic guard_q, guard_d;

  assign idle_block = tx_break || guard_q;
  assign restart    = (state_q == IDLE) && !(guard_q && !tx_break);
  assign tx_ready   = !hold_full_q && !(tx_break && (state_q == IDLE));

  always_comb begin
    guard_d = guard_q;
    if ((state_q == IDLE) && tx_break) begin
      guard_d = 1'b1;
    end else if (guard_q && tick) begin
      guard_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_q <= 1'b0;
    end else begin
      guard_q <= guard_d;
    end
  end
`else
  assign idle_block = 1'b0;
  assign restart    = (state_q == IDLE);
  assign tx_ready   = !hold_full_q;
`endif

  assign accept = tx_valid && tx_ready;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    par_d       = par_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q && !idle_block) begin
          load = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            if (HAS_PARITY) begin
              state_d = uart_pkg::PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            if (hold_full_q && !idle_block) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading frees the holding register, so a same-cycle accept can refill it.
    if (load) begin
      state_d     = START;
      shift_d     = hold_data_q;
      par_d       = parity_bit(^hold_data_q, PAR_MODE);
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    tx_d = 1'b1;
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      default:          tx_d = 1'b1;
    endcase
`ifdef UART_TX_BREAK_EN
    if ((state_d == IDLE) && tx_break) begin
      tx_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == STOP) && (stop_idx_q == LAST_STOP) && tick;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7N2) at CLK_PER_BAUD=4.
// Expected frames are hand-built vectors: bit b of the vector is the line level during bit period b.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] data_r [4];
  logic [3:0] valid_r;
  logic [3:0] ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic       brk;

  int checks   = 0;
  int failures = 0;

  uart_tx_frame u_def (
    .clk(clk), .rst(rst), .tx_data(data_r[0]), .tx_valid(valid_r[0]), .tx_ready(ready_w[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  uart_tx_frame #(.PARITY(2)) u_even (
    .clk(clk), .rst(rst), .tx_data(data_r[1]), .tx_valid(valid_r[1]), .tx_ready(ready_w[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  uart_tx_frame #(.PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(data_r[2]), .tx_valid(valid_r[2]), .tx_ready(ready_w[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(data_r[3][6:0]), .tx_valid(valid_r[3]), .tx_ready(ready_w[3]),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Presents a byte on instance k and returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input int k, input logic [7:0] data);
    int waitCycles = 0;
    @(negedge clk);
    data_r[k]  = data;
    valid_r[k] = 1'b1;
    while (!ready_w[k] && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_ready", 32'(ready_w[k]), 32'd1);
    @(negedge clk);
    valid_r[k] = 1'b0;
  endtask

  // Samples cycles 1..total after acceptance; optionally offers a second byte at cycle at2.
  task automatic captureFrames(input int k, input int total, input int flen, input logic [31:0] expVec,
                               input logic [7:0] data2, input int at2, input string tag);
    int          txBad = 0;
    int          doneCnt = 0;
    int          doneBad = 0;
    int          busyCnt = 0;
    int          acceptAt = 0;
    logic        readyAfter = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] obs = '0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (pend) begin
        valid_r[k] = 1'b0;
        pend       = 1'b0;
        acceptAt   = c - 1;
        readyAfter = ready_w[k];
      end
      if (at2 != 0 && c == at2) begin
        data_r[k]  = data2;
        valid_r[k] = 1'b1;
      end
      if (valid_r[k] && ready_w[k]) pend = 1'b1;
      if (tx_w[k] !== expVec[(c-1)/4]) txBad++;
      if ((c - 1) % 4 == 2) obs[(c-1)/4] = tx_w[k];
      if (busy_w[k]) busyCnt++;
      if (done_w[k]) begin
        doneCnt++;
        if (c % flen != 0) doneBad++;
      end
    end
    checkOutput({tag, "_bits"}, obs, expVec);
    checkOutput({tag, "_tx_cycles"}, 32'(txBad), 32'd0);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(total));
    checkOutput({tag, "_done_count"}, 32'(doneCnt), 32'(total / flen));
    checkOutput({tag, "_done_pos"}, 32'(doneBad), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_idle_after"}, {30'd0, busy_w[k], tx_w[k]}, 32'b01);
    if (at2 != 0) begin
      checkOutput({tag, "_accept2_cycle"}, 32'(acceptAt), 32'(at2));
      checkOutput({tag, "_ready_drop"}, 32'(readyAfter), 32'd0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    brk     = 1'b0;
    valid_r = '0;
    for (int i = 0; i < 4; i++) data_r[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx_w[0]), 32'd1);
    checkOutput("reset_ready", 32'(ready_w[0]), 32'd1);
    checkOutput("reset_busy", 32'(busy_w[0]), 32'd0);
    checkOutput("reset_done", 32'(done_w[0]), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 8N1 frame 0x30");
    applyStimulus(0, 8'h30);
    captureFrames(0, 40, 40, 32'h260, 8'h00, 0, "def_30");

    $display("[TB] even parity 0x07");
    applyStimulus(1, 8'h07);
    captureFrames(1, 44, 44, 32'h60E, 8'h00, 0, "even_07");

    $display("[TB] odd parity 0x07");
    applyStimulus(2, 8'h07);
    captureFrames(2, 44, 44, 32'h40E, 8'h00, 0, "odd_07");

    $display("[TB] 7 data bits, 2 stop bits, 0x7F");
    applyStimulus(3, 8'h7F);
    captureFrames(3, 40, 40, 32'h3FE, 8'h00, 0, "7n2_7f");

    $display("[TB] back-to-back 0x55 then 0xAA");
    applyStimulus(0, 8'h55);
    captureFrames(0, 80, 40, 32'hD52AA, 8'hAA, 6, "b2b");

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h11);
    repeat (8) @(negedge clk);
    checkOutput("rst_pre_tx_ready", {30'd0, tx_w[0], ready_w[0]}, 32'b00);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async", {29'd0, tx_w[0], ready_w[0], busy_w[0]}, 32'b110);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("rst_discard", {29'd0, busy_w[0], tx_w[0], ready_w[0]}, 32'b011);
    applyStimulus(0, 8'hA5);
    captureFrames(0, 40, 40, 32'h34A, 8'h00, 0, "after_rst_a5");

`ifdef UART_TX_BREAK_EN
    begin
      int highCnt = 0;
      int waitCycles = 0;
      logic sawZero = 1'b0;
      logic doneSeen = 1'b0;
      $display("[TB] line break");
      @(negedge clk);
      brk = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("brk_hold", {30'd0, tx_w[0], ready_w[0]}, 32'b00);
      data_r[0]  = 8'h0F;
      valid_r[0] = 1'b1;
      repeat (18) @(negedge clk);
      checkOutput("brk_end", {30'd0, tx_w[0], ready_w[0]}, 32'b00);
      brk = 1'b0;
      for (int c = 0; c < 40 && !sawZero; c++) begin
        @(negedge clk);
        valid_r[0] = 1'b0;
        if (tx_w[0] == 1'b0) sawZero = 1'b1;
        else highCnt++;
      end
      checkOutput("brk_start_seen", 32'(sawZero), 32'd1);
      checkOutput("brk_gap_ge4", 32'(highCnt >= 4), 32'd1);
      while (!doneSeen && waitCycles < 100) begin
        @(negedge clk);
        if (done_w[0]) doneSeen = 1'b1;
        waitCycles++;
      end
      checkOutput("brk_frame_done", 32'(doneSeen), 32'd1);
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
